// File: rtl/fifo_tx_pkg.sv
// Shared types and constants for the buffered USB FIFO transmit stage.
package fifo_tx_pkg;

    // Write-cycle sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_STROBE = 2'b10,
        ST_HOLD   = 2'b11
    } wr_state_e;

    localparam logic [6:0] ASCII_CR = 7'h0D;
    localparam logic [6:0] ASCII_LF = 7'h0A;

endpackage

// File: rtl/fifo_tx_if.sv
// Bundle of the PIA character side and the FT245 write side of fifo_tx.
interface fifo_tx_if #(
    parameter int unsigned DEPTH = 8
);
    logic                   char_valid;
    logic [6:0]             char_data;
    logic                   char_ready;
    logic                   fifo_txe;
    logic                   fifo_wr;
    logic [7:0]             fifo_dout;
    logic                   fifo_oe;
    logic [$clog2(DEPTH):0] count;

    // Driver of characters and of TXE# (PIA model / board).
    modport master (
        output char_valid, char_data, fifo_txe,
        input  char_ready, fifo_wr, fifo_dout, fifo_oe, count
    );

    // The transmit stage itself.
    modport slave (
        input  char_valid, char_data, fifo_txe,
        output char_ready, fifo_wr, fifo_dout, fifo_oe, count
    );
endinterface

// File: rtl/char_fifo.sv
// Synchronous circular buffer; push and pop on the same edge are both honoured.
module char_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned     PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0]   Full = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_q != '0);
    // A push into a full buffer is only legal when the head leaves on the same edge.
    assign do_push = push && ((count_q < Full) || do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/fifo_tx.sv
// PIA display to FT245 transmit stage: buffering, CR->CRLF expansion and WR# sequencing.
module fifo_tx
    import fifo_tx_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned WR_SETUP = 1,
    parameter int unsigned WR_PULSE = 2,
    parameter bit          CRLF     = 1'b1
) (
    input logic      clk,
    input logic      reset,
    fifo_tx_if.slave bus
);
    localparam int unsigned     CntW      = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] Full      = CntW'(DEPTH);
    localparam int unsigned     TimMax    = (WR_SETUP > WR_PULSE) ? WR_SETUP : WR_PULSE;
    localparam int unsigned     TimW      = (TimMax > 1) ? $clog2(TimMax) : 1;
    localparam logic [TimW-1:0] SetupLoad = TimW'(WR_SETUP - 1);
    localparam logic [TimW-1:0] PulseLoad = TimW'(WR_PULSE - 1);

    wr_state_e       state_q;
    logic [TimW-1:0] timer_q;
    logic            pending_lf_q;
    logic            wr_q;
    logic            oe_q;
    logic [7:0]      dout_q;

    logic [CntW-1:0] count;
    logic [7:0]      head;
    logic [7:0]      push_data;
    logic            space;
    logic            ready;
    logic            char_push;
    logic            lf_push;
    logic            push;
    logic            pop;

    assign space     = count < Full;
    assign ready     = !pending_lf_q && space;
    assign char_push = bus.char_valid && ready;
    // The pending LF has priority; input is blocked while it waits, so the two never collide.
    assign lf_push   = pending_lf_q && space;
    assign push      = char_push || lf_push;
    assign push_data = lf_push ? {1'b0, ASCII_LF} : {1'b0, bus.char_data};
    assign pop       = (state_q == ST_STROBE) && (timer_q == '0);

    assign bus.char_ready = ready;
    assign bus.fifo_wr    = wr_q;
    assign bus.fifo_oe    = oe_q;
    assign bus.fifo_dout  = dout_q;
    assign bus.count      = count;

    char_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_char_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Arm the LF insertion after an accepted CR; clear once the LF is enqueued.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_lf_q <= 1'b0;
        end else if (lf_push) begin
            pending_lf_q <= 1'b0;
        end else if (CRLF && char_push && (bus.char_data == ASCII_CR)) begin
            pending_lf_q <= 1'b1;
        end
    end

    // Write-cycle sequencer: setup, WR# strobe, hold; TXE# only matters in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            wr_q    <= 1'b1;
            oe_q    <= 1'b0;
            dout_q  <= 8'h00;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if ((count != '0) && !bus.fifo_txe) begin
                        dout_q  <= head;
                        oe_q    <= 1'b1;
                        timer_q <= SetupLoad;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (timer_q == '0) begin
                        wr_q    <= 1'b0;
                        timer_q <= PulseLoad;
                        state_q <= ST_STROBE;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (timer_q == '0) begin
                        wr_q    <= 1'b1;
                        state_q <= ST_HOLD;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    oe_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule
